// File: rtl/snake_pkg.sv
// snake_pkg: constants and types shared by the snake controller and the apple generator
package snake_pkg;
  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b10;
  localparam logic [5:0] X_MIN = 6'd1;
  localparam logic [5:0] X_MAX = 6'd28;
  localparam logic [5:0] Y_MIN = 6'd1;
  localparam logic [5:0] Y_MAX = 6'd15;
  localparam int CELL_SHIFT = 4;
  localparam logic [11:0] H_RES = 12'd480;
  localparam logic [11:0] V_RES = 12'd272;
  typedef enum logic [1:0] {ARMED, EAT, SPAWN} apple_state_t;
  function automatic logic in_field(input logic [5:0] x, input logic [5:0] y);
    return x >= X_MIN && x <= X_MAX && y >= Y_MIN && y <= Y_MAX;
  endfunction
endpackage

// File: rtl/apple_gen_if.sv
// apple_gen_if: game status, head, scan position in; apple cell, grow request, pixel flag out
interface apple_gen_if;
  logic [1:0] game_status;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [5:0] apple_x;
  logic [5:0] apple_y;
  logic add_cube;
  logic apple_pix;
  logic [7:0] eat_cnt;
  modport master(output game_status, head_x, head_y, x_pos, y_pos,
                 input apple_x, apple_y, add_cube, apple_pix, eat_cnt);
  modport slave(input game_status, head_x, head_y, x_pos, y_pos,
                output apple_x, apple_y, add_cube, apple_pix, eat_cnt);
endinterface

// File: rtl/apple_gen_lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR; a zero seed is replaced by 1
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);
  localparam logic [15:0] INIT = (SEED == 16'd0) ? 16'd1 : SEED;
  // shift right, folding the taps in whenever a one falls out
  always_ff @(posedge clk)
    if (rst) q <= INIT;
    else if (en) q <= (q >> 1) ^ (q[0] ? TAPS : 16'd0);
endmodule

// File: rtl/apple_gen.sv
// apple_gen: apple cell holder, eat detector, grow pulse and respawn for the snake game
module apple_gen
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int ADD_PULSE = 4,
  parameter int MAX_TRIES = 32,
  parameter logic [5:0] INIT_X = 6'd24,
  parameter logic [5:0] INIT_Y = 6'd10
) (
  input logic clk,
  input logic rst,
  apple_gen_if.slave bus
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [3:0] PULSE_LAST = 4'(ADD_PULSE - 1);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  apple_state_t state;
  logic [15:0] lfsr;
  logic [5:0] apple_x, apple_y, cx, cy, fb_x, fb_y;
  logic [3:0] pulse_cnt;
  logic [TW-1:0] tries;
  logic [7:0] eat_cnt;
  logic add_cube, hit, accept, unused_bits;
  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .en(1'b1), .q(lfsr));
  assign unused_bits = ^{lfsr[15:12], lfsr[7:5]};
  assign cx = {1'b0, lfsr[4:0]} + 6'd1;
  assign cy = {2'b0, lfsr[11:8]} + 6'd1;
  assign accept = in_field(cx, cy) && !(cx == bus.head_x && cy == bus.head_y);
  assign fb_x = bus.head_x <= 6'd14 ? 6'd21 : 6'd7;
  assign fb_y = bus.head_y <= 6'd8 ? 6'd12 : 6'd4;
  assign hit = bus.game_status == GS_PLAY && bus.head_x == apple_x && bus.head_y == apple_y;
  assign bus.apple_x = apple_x;
  assign bus.apple_y = apple_y;
  assign bus.add_cube = add_cube;
  assign bus.eat_cnt = eat_cnt;
  assign bus.apple_pix = bus.x_pos < H_RES && bus.y_pos < V_RES && state != SPAWN &&
                         bus.x_pos[CELL_SHIFT +: 6] == apple_x && bus.y_pos[CELL_SHIFT +: 6] == apple_y;
  // eat detection, grow pulse timing and respawn draws; RESTART overrides everything but rst
  always_ff @(posedge clk) begin
    if (rst || bus.game_status == GS_RESTART) begin
      state <= ARMED;
      apple_x <= INIT_X;
      apple_y <= INIT_Y;
      add_cube <= 1'b0;
      eat_cnt <= 8'd0;
      pulse_cnt <= 4'd0;
      tries <= '0;
    end else begin
      case (state)
        ARMED:
          if (hit) begin
            state <= EAT;
            add_cube <= 1'b1;
            pulse_cnt <= 4'd0;
            eat_cnt <= eat_cnt + {7'd0, eat_cnt != 8'hFF};
          end
        EAT:
          if (pulse_cnt == PULSE_LAST) begin
            state <= SPAWN;
            add_cube <= 1'b0;
            tries <= '0;
          end else pulse_cnt <= pulse_cnt + 4'd1;
        SPAWN:
          if (accept || tries == TRY_LAST) begin
            state <= ARMED;
            apple_x <= accept ? cx : fb_x;
            apple_y <= accept ? cy : fb_y;
          end else tries <= tries + TW'(1);
        default: state <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_apple_gen.sv
// tb_apple_gen: two apple_gen instances against a cycle model through an expected-value queue
module tb_apple_gen;
  typedef struct {
    int st;
    logic [15:0] lfsr;
    int ax, ay, add, ec, pc, tries, fb;
  } mdl_t;
  typedef struct packed {
    logic [5:0] ax, ay;
    logic add;
    logic [7:0] ec;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] gs;
  int hx, hy, eats, errs, checks;
  bit chase;
  mdl_t m1, m2;
  exp_t q1[$], q2[$];
  apple_gen_if a1();
  apple_gen_if a2();
  apple_gen u1 (.clk(clk), .rst(rst), .bus(a1.slave));
  apple_gen #(.MAX_TRIES(2)) u2 (.clk(clk), .rst(rst), .bus(a2.slave));
  always #10 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic mdl_t step(mdl_t m, logic r, logic [1:0] s, int x, int y, int mt);
    mdl_t n = m;
    int cx, cy;
    if (r) begin
      n.st = 0; n.lfsr = 16'hACE1; n.ax = 24; n.ay = 10; n.add = 0; n.ec = 0; n.pc = 0; n.tries = 0;
      return n;
    end
    n.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 16'hB400) : (m.lfsr >> 1);
    if (s == 2'b00) begin
      n.st = 0; n.ax = 24; n.ay = 10; n.add = 0; n.ec = 0;
      return n;
    end
    if (m.st == 0 && s == 2'b10 && x == m.ax && y == m.ay) begin
      n.st = 1; n.add = 1; n.pc = 0; n.ec = (m.ec == 255) ? 255 : m.ec + 1;
    end else if (m.st == 1) begin
      n.pc = m.pc + 1;
      if (n.pc == 4) begin n.st = 2; n.add = 0; n.tries = 0; end
    end else if (m.st == 2) begin
      cx = int'(m.lfsr[4:0]) + 1;
      cy = int'(m.lfsr[11:8]) + 1;
      if (cx <= 28 && cy <= 15 && !(cx == x && cy == y)) begin
        n.ax = cx; n.ay = cy; n.st = 0;
      end else begin
        n.tries = m.tries + 1;
        if (n.tries == mt) begin
          n.ax = (x <= 14) ? 21 : 7; n.ay = (y <= 8) ? 12 : 4; n.st = 0; n.fb = m.fb + 1;
        end
      end
    end
    return n;
  endfunction
  function automatic logic exp_pix(mdl_t m, int x, int y);
    return m.st != 2 && x < 480 && y < 272 && x / 16 == m.ax && y / 16 == m.ay;
  endfunction
  function automatic logic in_rng(logic [5:0] x, logic [5:0] y);
    return x >= 6'd1 && x <= 6'd28 && y >= 6'd1 && y <= 6'd15;
  endfunction
  task automatic tick();
    mdl_t n1, n2;
    exp_t e;
    int h1x, h1y, h2x, h2y, px, py, sel;
    h1x = chase ? m1.ax : hx; h1y = chase ? m1.ay : hy;
    h2x = chase ? m2.ax : hx; h2y = chase ? m2.ay : hy;
    a1.game_status = gs; a2.game_status = gs;
    a1.head_x = 6'(h1x); a1.head_y = 6'(h1y);
    a2.head_x = 6'(h2x); a2.head_y = 6'(h2y);
    n1 = step(m1, rst, gs, h1x, h1y, 32);
    n2 = step(m2, rst, gs, h2x, h2y, 2);
    if (!rst && m1.st == 0 && n1.st == 1) eats++;
    q1.push_back({6'(n1.ax), 6'(n1.ay), 1'(n1.add), 8'(n1.ec)});
    q2.push_back({6'(n2.ax), 6'(n2.ay), 1'(n2.add), 8'(n2.ec)});
    @(posedge clk);
    #1;
    e = q1.pop_front();
    chk("u1_out", 32'({a1.apple_x, a1.apple_y, a1.add_cube, a1.eat_cnt}), 32'(e));
    e = q2.pop_front();
    chk("u2_out", 32'({a2.apple_x, a2.apple_y, a2.add_cube, a2.eat_cnt}), 32'(e));
    if (!rst && gs != 2'b00 && m1.st == 2 && n1.st == 0) begin
      chk("u1_range", 32'(in_rng(a1.apple_x, a1.apple_y)), 32'd1);
      chk("u1_offhead", 32'({a1.apple_x, a1.apple_y} != {6'(h1x), 6'(h1y)}), 32'd1);
    end
    if (!rst && gs != 2'b00 && m2.st == 2 && n2.st == 0) begin
      chk("u2_range", 32'(in_rng(a2.apple_x, a2.apple_y)), 32'd1);
      chk("u2_offhead", 32'({a2.apple_x, a2.apple_y} != {6'(h2x), 6'(h2y)}), 32'd1);
    end
    m1 = n1; m2 = n2;
    sel = $urandom_range(0, 2);
    px = sel == 0 ? m1.ax * 16 + $urandom_range(0, 15) : sel == 1 ? 1024 + m1.ax * 16 : $urandom_range(0, 511);
    py = sel == 0 ? m1.ay * 16 + $urandom_range(0, 15) : sel == 1 ? m1.ay * 16 + 1024 : $urandom_range(0, 300);
    a1.x_pos = 12'(px); a1.y_pos = 12'(py);
    a2.x_pos = 12'(px); a2.y_pos = 12'(py);
    #1;
    chk("u1_pix", 32'(a1.apple_pix), 32'(exp_pix(m1, px, py)));
    chk("u2_pix", 32'(a2.apple_pix), 32'(exp_pix(m2, px, py)));
  endtask
  task automatic probe(input string tag, input int x, input int y, input logic e);
    a1.x_pos = 12'(x); a1.y_pos = 12'(y);
    #1;
    chk(tag, 32'(a1.apple_pix), 32'(e));
  endtask
  initial begin
    logic [5:0] bits;
    int rises;
    logic prev;
    errs = 0; checks = 0; eats = 0;
    rst = 1'b1; gs = 2'b10; hx = 10; hy = 5; chase = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ax", 32'(a1.apple_x), 32'd24);
    chk("rst_ay", 32'(a1.apple_y), 32'd10);
    chk("rst_add", 32'(a1.add_cube), 32'd0);
    chk("rst_ec", 32'(a1.eat_cnt), 32'd0);
    probe("pix_in_lo", 384, 160, 1'b1);
    probe("pix_in_hi", 399, 175, 1'b1);
    probe("pix_x_lo", 383, 160, 1'b0);
    probe("pix_x_hi", 400, 175, 1'b0);
    probe("pix_y_lo", 384, 159, 1'b0);
    probe("pix_y_hi", 399, 176, 1'b0);
    repeat (10) tick();
    chk("idle_ax", 32'(a1.apple_x), 32'd24);
    chk("idle_ec", 32'(a1.eat_cnt), 32'd0);
    gs = 2'b11; hx = 24; hy = 10;
    repeat (5) tick();
    chk("frozen_ec", 32'(a1.eat_cnt), 32'd0);
    chk("frozen_add", 32'(a1.add_cube), 32'd0);
    gs = 2'b10;
    bits = '0;
    tick();
    bits[0] = a1.add_cube;
    hx = 10; hy = 5;
    for (int i = 1; i < 6; i++) begin
      tick();
      bits[i] = a1.add_cube;
    end
    chk("pulse_shape", 32'(bits), 32'b001111);
    chk("eat_one", 32'(a1.eat_cnt), 32'd1);
    for (int i = 0; i < 40 && m1.st != 0; i++) tick();
    chk("new_range", 32'(in_rng(a1.apple_x, a1.apple_y)), 32'd1);
    chk("new_moved", 32'({a1.apple_x, a1.apple_y} != {6'd24, 6'd10}), 32'd1);
    gs = 2'b00;
    tick();
    chk("restart_ax", 32'(a1.apple_x), 32'd24);
    chk("restart_ay", 32'(a1.apple_y), 32'd10);
    chk("restart_ec", 32'(a1.eat_cnt), 32'd0);
    gs = 2'b10; hx = 24; hy = 10;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a1.add_cube && !prev) rises++;
      prev = a1.add_cube;
    end
    chk("hold_pulses", 32'(rises), 32'd1);
    chk("hold_ec", 32'(a1.eat_cnt), 32'd1);
    gs = 2'b00;
    tick();
    gs = 2'b10;
    tick();
    hx = 10; hy = 5;
    tick();
    chk("eat2_add", 32'(a1.add_cube), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_eat_add", 32'(a1.add_cube), 32'd0);
    chk("rst_eat_apple", 32'({a1.apple_x, a1.apple_y}), 32'({6'd24, 6'd10}));
    chk("rst_eat_ec", 32'(a1.eat_cnt), 32'd0);
    hx = 24; hy = 10;
    tick();
    hx = 10; hy = 5;
    tick();
    gs = 2'b00;
    tick();
    chk("rs_eat_add", 32'(a1.add_cube), 32'd0);
    chk("rs_eat_apple", 32'({a1.apple_x, a1.apple_y}), 32'({6'd24, 6'd10}));
    chk("rs_eat_ec", 32'(a1.eat_cnt), 32'd0);
    gs = 2'b10; chase = 1'b1; eats = 0;
    for (int i = 0; i < 4000 && eats < 300; i++) tick();
    chk("eat_budget", 32'(eats >= 300), 32'd1);
    chk("eat_sat", 32'(a1.eat_cnt), 32'd255);
    chk("fallback_seen", 32'(m2.fb > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/apple_gen.md
# apple_gen

Food source for the snake game: holds the current apple cell, detects when the snake head reaches it, and drives the `add_cube` grow request that the snake controller consumes. After each eat it draws a new in-field cell from a free-running LFSR, never on the head cell. It also supplies the apple pixel flag to the display mux for the current scan position. It sits between the snake controller (head coordinates in, `add_cube` out) and the renderer.

## Interface

Parameters:
- `SEED`, 16'hACE1: LFSR reset value. Zero is forced to 1.
- `ADD_PULSE`, 4: number of cycles `add_cube` stays high per eat (1..15).
- `MAX_TRIES`, 32: maximum LFSR draws per respawn before the fallback cell is used.
- `INIT_X`, 24 / `INIT_Y`, 10: apple cell after reset and RESTART.

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst`  in  1  reset, synchronous, active-high
- `game_status`  in  2  00 RESTART, 10 PLAY, other values frozen
- `head_x`  in  6  snake head cell column
- `head_y`  in  6  snake head cell row
- `x_pos`  in  12  scan pixel column (0..479)
- `y_pos`  in  12  scan pixel row (0..271)
- `apple_x`  out  6  apple cell column
- `apple_y`  out  6  apple cell row
- `add_cube`  out  1  grow request to the snake controller
- `apple_pix`  out  1  current scan pixel lies in the apple cell
- `eat_cnt`  out  8  apples eaten since reset or RESTART; saturates at 255

## Operation

- Cells are 16×16 px. The valid apple field is x 1..28 and y 1..15.
- FSM states:
  - ARMED: apple visible. If `game_status`==PLAY and {head_x,head_y}=={apple_x,apple_y}, go to EAT. Otherwise stay.
  - EAT: `add_cube`=1. A counter runs for ADD_PULSE cycles, then the FSM goes to SPAWN and `add_cube`=0.
  - SPAWN: one draw per cycle.
    - Candidate: cx=lfsr[4:0]+1, cy=lfsr[11:8]+1.
    - Accept if cx≤28, cy≤15, and (cx,cy)≠(head_x,head_y). On accept, load apple_x/apple_y and go to ARMED.
    - On the MAX_TRIES-th reject, use the fallback cell (head_x≤14 ? 21 : 7, head_y≤8 ? 12 : 4), which is guaranteed off-head. Then go to ARMED.
- LFSR: 16-bit Galois, taps 16'hB400, right shift. It advances every cycle, including during RESTART. It is reloaded only by `rst`.
- `eat_cnt` increments on the ARMED→EAT transition and saturates at 255.
- `apple_pix` is combinational: x_pos<480, y_pos<272, x_pos[9:4]==apple_x, y_pos[9:4]==apple_y, and state≠SPAWN.
- `game_status`==RESTART, from any state: apple returns to (INIT_X,INIT_Y), `eat_cnt`=0, `add_cube`=0, state ARMED. RESTART takes effect on the same edge.
- Non-PLAY, non-RESTART status: ARMED does no compare. EAT and SPAWN run to completion, so a pending grow request is not lost.

## Timing

- Reset values: apple_x=INIT_X, apple_y=INIT_Y, add_cube=0, eat_cnt=0, state ARMED, lfsr=SEED. `apple_pix` follows from these.
- Match sampled at edge N (ARMED, PLAY). From edge N+1:
  - `add_cube` is 1 for exactly ADD_PULSE cycles.
  - `eat_cnt` updates at N+1.
  - SPAWN is entered at N+1+ADD_PULSE.
- SPAWN lasts 1..MAX_TRIES cycles. New apple_x/apple_y are valid in the same cycle as ARMED re-entry.
- `add_cube` is always low for ≥1 cycle between pulses. This satisfies the snake controller's rise-then-release latch, giving exactly one grow per eat.
- The head moves only every 12.5 M cycles and the apple has moved before ARMED returns, so one eat cannot retrigger.
- `rst` asserted mid-EAT: `add_cube` is 0 on the next edge, with no residual pulse.

## Structure

- Shared package `snake_pkg`:
  - game status codes (RESTART, PLAY)
  - field bounds X_MIN=1, X_MAX=28, Y_MIN=1, Y_MAX=15
  - CELL_SHIFT=4
  - the snake controller imports the same constants.
- Sub-module `lfsr16`: Galois LFSR with seed parameter and enable. Instantiated once here, and reusable for any later obstacle placement.
- The FSM, counters and pixel compare stay in `apple_gen`.

## Test plan

- Reset with SEED=16'hACE1, then idle in PLAY with head (10,5): apple stays at (24,10), add_cube=0, eat_cnt=0, apple_pix=1 only for x_pos 384..399 and y_pos 160..175.
- Drive head (24,10) in PLAY for one cycle: add_cube high exactly 4 cycles starting the next edge, eat_cnt=1, new apple within x 1..28, y 1..15 and ≠ (24,10), apple_pix=0 during SPAWN.
- Hold head on the apple for 100 cycles: exactly one add_cube pulse, eat_cnt=1.
- Force the LFSR to yield only rejected candidates with MAX_TRIES=2 and head (3,3): apple=(21,12) after 2 SPAWN cycles.
- Assert `rst` on the 2nd EAT cycle: add_cube=0, apple=(24,10), eat_cnt=0 next cycle. Repeat with game_status=RESTART instead: same result, LFSR not reloaded.
- 300 eats in a row: eat_cnt saturates at 255, every apple is in range and off-head.
